mult_hilo_sequencer: RTL and testbench

- Sits between the multicycle control unit and the shift-add multiplier core.
- Accepts MULT/MULTU requests and hands unsigned operand magnitudes to the core.
- Waits for the core's done flag, applies the sign fix-up to the 64-bit product and commits it to the HI/LO architectural registers.
- Holds the control unit stalled while busy; serves MFHI/MFLO reads and MTHI/MTLO writes.

---
 rtl/mult_hilo_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mult_hilo_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_hilo_sequencer.sv
// ============================================================================
//  Module   : mult_hilo_sequencer
//  Purpose  : Sequences MULT/MULTU between the multicycle control unit and an
//             unsigned shift-add multiplier core. Operand magnitudes go to the
//             core, the sign is re-applied to the 64-bit product, and the
//             result is committed to the HI/LO architectural registers.
//             MTHI/MTLO writes are taken while idle.
//  Ports    : Clk, Reset          - clock, synchronous active-high reset
//             req_i, req_signed_i - one-cycle multiply request, 1 = signed
//             op_a_i, op_b_i      - rs / rt operands, sampled with req_i
//             mthi_i, mtlo_i      - write wr_data_i into HI / LO (idle only)
//             wr_data_i           - data for MTHI/MTLO
//             mul_a_o, mul_b_o    - registered operand magnitudes to the core
//             mul_start_o         - one-cycle start pulse to the core
//             mul_done_i          - core completion flag
//             mul_product_i       - unsigned core product, valid with done
//             hi_o, lo_o          - HI / LO registers
//             busy_o              - stall to the control unit
//             timeout_err_o       - sticky abort flag, cleared by Reset only
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_hilo_sequencer #(
  parameter int TIMEOUT = 40,  // max cycles in WAIT for the core
  parameter int CNT_W   = 6    // wait counter width, 2^CNT_W > TIMEOUT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_i,
  input  logic        req_signed_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  output logic        mul_start_o,
  input  logic        mul_done_i,
  input  logic [63:0] mul_product_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        timeout_err_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_FIXUP  = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

  // WAIT gives up once the counter would reach TIMEOUT, so the core gets
  // exactly TIMEOUT WAIT cycles to raise done.
  localparam logic [CNT_W-1:0] LAST_WAIT_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [63:0]       prod_q, prod_d;
  logic [31:0]       mul_a_q, mul_a_d;
  logic [31:0]       mul_b_q, mul_b_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              terr_q, terr_d;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      terr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    terr_d  = terr_q;

    case (state_q)
      S_IDLE: begin
        // MT writes and a new request may coincide; the multiply result
        // simply overwrites HI/LO later.
        if (mthi_i) hi_d = wr_data_i;
        if (mtlo_i) lo_d = wr_data_i;
        if (req_i) begin
          neg_d   = req_signed_i & (op_a_i[31] ^ op_b_i[31]);
          // Negating -2^31 yields 32'h8000_0000, which is the correct
          // unsigned magnitude for the core.
          mul_a_d = (req_signed_i && op_a_i[31]) ? (~op_a_i + 32'd1) : op_a_i;
          mul_b_d = (req_signed_i && op_b_i[31]) ? (~op_b_i + 32'd1) : op_b_i;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (mul_done_i) begin
          prod_d  = mul_product_i;
          state_d = S_FIXUP;
        end else if (cnt_q == LAST_WAIT_CNT) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FIXUP: begin
        if (neg_q) prod_d = ~prod_q + 64'd1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        hi_d    = prod_q[63:32];
        lo_d    = prod_q[31:0];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mul_a_o       = mul_a_q;
  assign mul_b_o       = mul_b_q;
  assign mul_start_o   = (state_q == S_LAUNCH);
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign busy_o        = (state_q != S_IDLE);
  assign timeout_err_o = terr_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_hilo_sequencer.sv
// ============================================================================
//  Module   : tb_mult_hilo_sequencer
//  Purpose  : Self-checking bench for mult_hilo_sequencer. Stimulus pushes
//             expected launches and results into queues; a monitor pops and
//             compares on every mul_start pulse and every busy falling edge.
//             A separate process plays the multiplier core.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_hilo_sequencer;

  localparam int TIMEOUT = 40;
  localparam int CNT_W   = 6;

  logic        Clk;
  logic        Reset;
  logic        req, req_signed, mthi, mtlo, mul_done;
  logic [31:0] op_a, op_b, wr_data;
  logic [63:0] mul_product;
  logic [31:0] mul_a, mul_b, hi, lo;
  logic        mul_start, busy, timeout_err;

  mult_hilo_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .req_i         (req),
    .req_signed_i  (req_signed),
    .op_a_i        (op_a),
    .op_b_i        (op_b),
    .mthi_i        (mthi),
    .mtlo_i        (mtlo),
    .wr_data_i     (wr_data),
    .mul_a_o       (mul_a),
    .mul_b_o       (mul_b),
    .mul_start_o   (mul_start),
    .mul_done_i    (mul_done),
    .mul_product_i (mul_product),
    .hi_o          (hi),
    .lo_o          (lo),
    .busy_o        (busy),
    .timeout_err_o (timeout_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } launch_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        terr;
    int          len;   // expected busy cycles, -1 = don't care
  } res_t;

  launch_t     launch_q[$];
  res_t        res_q[$];
  int          core_d_q[$];      // core delay after start, -1 = never done
  logic [63:0] core_p_q[$];

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_hi, model_lo;
  logic        model_terr;
  launch_t     l_tmp;
  res_t        r_tmp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Issue one multiply, push its expectations, and wait until idle again.
  task automatic do_mult(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input int d, input bit extra_req, input bit with_mt,
                         input bit mthi_busy);
    longint      sa, sb;
    logic [63:0] ma, mb, prod;
    logic [31:0] wd;
    launch_t     l;
    res_t        r;
    int          n, xi;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sgn) prod = 64'(sa * sb);
    else     prod = {32'd0, a} * {32'd0, b};
    ma = (sgn && a[31]) ? 64'(-sa) : {32'd0, a};
    mb = (sgn && b[31]) ? 64'(-sb) : {32'd0, b};
    l.a = ma[31:0];
    l.b = mb[31:0];
    launch_q.push_back(l);
    core_d_q.push_back(d);
    core_p_q.push_back(ma * mb);
    wd = $urandom();
    if (with_mt) model_lo = wd;
    if (d >= 1 && d <= TIMEOUT) begin
      model_hi = prod[63:32];
      model_lo = prod[31:0];
      r.len    = d + 3;
    end else begin
      model_terr = 1'b1;
      r.len      = 1 + TIMEOUT;
    end
    r.hi   = model_hi;
    r.lo   = model_lo;
    r.terr = model_terr;
    res_q.push_back(r);

    req = 1'b1; req_signed = sgn; op_a = a; op_b = b; mtlo = with_mt; wr_data = wd;
    cyc();
    req = 1'b0; mtlo = 1'b0; op_a = $urandom(); op_b = $urandom();
    if (with_mt) check("mtlo_with_req", 64'(lo), 64'(wd));

    n  = 0;
    xi = int'($urandom_range(0, 2));
    while (busy === 1'b1 && n < 200) begin
      if (extra_req && n == xi) begin
        req = 1'b1; req_signed = 1'($urandom_range(0, 1));
        op_a = $urandom(); op_b = $urandom();
      end
      if (mthi_busy && n == xi + 1) begin
        mthi = 1'b1; wr_data = $urandom();
      end
      cyc();
      req = 1'b0; mthi = 1'b0;
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL busy_bound: got busy=%0b after %0d cycles want 0", busy, n);
    end
  endtask

  // Multiplier core model: answers each mul_start after the queued delay.
  initial begin
    int          d;
    logic [63:0] p;
    mul_done    = 1'b0;
    mul_product = {$urandom(), $urandom()};
    forever begin
      @(negedge Clk);
      if (mul_start === 1'b1 && core_d_q.size() > 0) begin
        d = core_d_q.pop_front();
        p = core_p_q.pop_front();
        if (d >= 0) begin
          repeat (d) @(posedge Clk);
          #1;
          mul_done = 1'b1; mul_product = p;
          @(posedge Clk);
          #1;
          mul_done = 1'b0; mul_product = {$urandom(), $urandom()};
        end
      end
    end
  end

  // Monitor: compare launches and committed results as the DUT presents them.
  initial begin
    int      blen;
    bit      pb;
    launch_t l;
    res_t    r;
    blen = 0;
    pb   = 1'b0;
    forever begin
      @(negedge Clk);
      if (mul_start === 1'b1) begin
        if (launch_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_start: got mul_start=1 want 0 at %0t", $time);
        end else begin
          l = launch_q.pop_front();
          check("mul_a", 64'(mul_a), 64'(l.a));
          check("mul_b", 64'(mul_b), 64'(l.b));
        end
      end
      if (busy === 1'b1) begin
        blen++;
      end else if (pb) begin
        if (res_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got busy fall want none at %0t", $time);
        end else begin
          r = res_q.pop_front();
          check("hi", 64'(hi), 64'(r.hi));
          check("lo", 64'(lo), 64'(r.lo));
          check("timeout_err", 64'(timeout_err), 64'(r.terr));
          if (r.len >= 0) check("busy_len", 64'(blen), 64'(r.len));
        end
        blen = 0;
      end
      pb = (busy === 1'b1);
    end
  end

  // Stimulus
  initial begin
    Reset = 1'b1; req = 1'b0; req_signed = 1'b0; op_a = '0; op_b = '0;
    mthi = 1'b0; mtlo = 1'b0; wr_data = '0;
    model_hi = '0; model_lo = '0; model_terr = 1'b0;
    repeat (3) cyc();
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    check("rst_mul_start", 64'(mul_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    Reset = 1'b0;
    cyc();

    // Directed cases
    do_mult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0, 1'b0, 1'b0);
    do_mult(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 5, 1'b0, 1'b0, 1'b0);
    do_mult(1'b1, 32'h8000_0000, 32'h8000_0000, 1, 1'b0, 1'b0, 1'b0);

    mthi = 1'b1; wr_data = 32'h0000_1234;
    cyc();
    mthi = 1'b0;
    model_hi = 32'h0000_1234;
    check("mthi_idle", 64'(hi), 64'h1234);
    do_mult(1'b1, 32'h0000_0010, 32'hFFFF_FFF0, 7, 1'b1, 1'b0, 1'b0);

    do_mult(1'b0, 32'h0001_0000, 32'h0001_0000, TIMEOUT, 1'b0, 1'b1, 1'b0);

    // Randomized operations
    for (int k = 0; k < 16; k++) begin
      do_mult(1'($urandom_range(0, 1)), pick_operand(), pick_operand(),
              int'($urandom_range(1, TIMEOUT)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0);
    end

    // Core never answers: abort, HI/LO untouched, dropped MTHI while busy
    do_mult(1'b1, 32'h1234_5678, 32'h8765_4321, -1, 1'b1, 1'b0, 1'b1);
    repeat (3) cyc();
    check("timeout_sticky", 64'(timeout_err), 64'd1);
    do_mult(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 12, 1'b0, 1'b0, 1'b0);

    // Reset while in WAIT, core answers two cycles later
    l_tmp.a = 32'd5; l_tmp.b = 32'd6;
    launch_q.push_back(l_tmp);
    core_d_q.push_back(6);
    core_p_q.push_back(64'd30);
    r_tmp.hi = '0; r_tmp.lo = '0; r_tmp.terr = 1'b0; r_tmp.len = -1;
    res_q.push_back(r_tmp);
    req = 1'b1; req_signed = 1'b0; op_a = 32'd5; op_b = 32'd6;
    cyc();
    req = 1'b0;
    repeat (4) cyc();
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_timeout_err", 64'(timeout_err), 64'd0);
    check("midrst_mul_a", 64'(mul_a), 64'd0);
    repeat (6) cyc();
    check("late_done_hi", 64'(hi), 64'd0);
    check("late_done_lo", 64'(lo), 64'd0);
    check("late_done_busy", 64'(busy), 64'd0);
    model_hi = '0; model_lo = '0; model_terr = 1'b0;

    do_mult(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 20, 1'b0, 1'b0, 1'b0);

    repeat (5) cyc();
    check("launch_q_empty", 64'(launch_q.size()), 64'd0);
    check("res_q_empty", 64'(res_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got no completion want finish by time %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
